// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// drives memory handshakes, datapath enables and mux selects, and traps stickily.
module rv_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic             branch_taken,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ClsR, ClsIalu, ClsLoad, ClsStore, ClsBranch,
        ClsJal, ClsJalr, ClsLui, ClsAuipc, ClsFence
    } class_e;

    state_e           state_q;
    class_e           cls_q;
    class_e           dec_cls;
    logic             dec_legal;
    logic             dec_sys;
    logic [1:0]       cause_q;
    logic [31:0]      wait_q;
    logic [CNT_W-1:0] instret_q;
    logic             timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == MEM_TIMEOUT);

    always_comb begin
        dec_cls   = ClsR;
        dec_legal = 1'b1;
        dec_sys   = 1'b0;
        case (opcode)
            7'b0110011: dec_cls = ClsR;
            7'b0010011: dec_cls = ClsIalu;
            7'b0000011: dec_cls = ClsLoad;
            7'b0100011: dec_cls = ClsStore;
            7'b1100011: dec_cls = ClsBranch;
            7'b1101111: dec_cls = ClsJal;
            7'b1100111: dec_cls = ClsJalr;
            7'b0110111: dec_cls = ClsLui;
            7'b0010111: dec_cls = ClsAuipc;
            7'b0001111: dec_cls = ClsFence;
            7'b1110011: begin
                dec_legal = 1'b0;
                dec_sys   = 1'b1;
            end
            default:    dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            cls_q     <= ClsR;
            cause_q   <= 2'd0;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    // Ready on the timeout cycle still counts as a successful fetch.
                    if (imem_ready) begin
                        state_q <= StDecode;
                        wait_q  <= '0;
                    end else if (timeout_hit) begin
                        state_q <= StTrap;
                        cause_q <= 2'd2;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                StDecode: begin
                    if (dec_legal) begin
                        cls_q   <= dec_cls;
                        state_q <= StExec;
                    end else begin
                        state_q <= StTrap;
                        cause_q <= dec_sys ? 2'd1 : 2'd0;
                    end
                end
                StExec: begin
                    wait_q <= '0;
                    if (cls_q == ClsBranch) begin
                        state_q   <= StFetch;
                        instret_q <= instret_q + CNT_W'(1);
                    end else if (cls_q == ClsLoad || cls_q == ClsStore) begin
                        state_q <= StMem;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StMem: begin
                    if (dmem_ready) begin
                        wait_q <= '0;
                        if (cls_q == ClsStore) begin
                            state_q   <= StFetch;
                            instret_q <= instret_q + CNT_W'(1);
                        end else begin
                            state_q <= StWb;
                        end
                    end else if (timeout_hit) begin
                        state_q <= StTrap;
                        cause_q <= 2'd3;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                StWb: begin
                    wait_q    <= '0;
                    state_q   <= StFetch;
                    instret_q <= instret_q + CNT_W'(1);
                end
                StTrap: ;
                default: begin
                    state_q <= StTrap;
                    cause_q <= 2'd0;
                end
            endcase
        end
    end

    // Outputs are forced low for the whole reset cycle, not just after it.
    always_comb begin
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'd0;
        alu_a_sel  = 2'd0;
        alu_b_sel  = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 2'd0;
        trap       = 1'b0;
        trap_cause = 2'd0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                StExec: begin
                    case (cls_q)
                        ClsIalu, ClsLoad, ClsStore, ClsJalr: alu_b_sel = 1'b1;
                        ClsLui: begin
                            alu_a_sel = 2'd2;
                            alu_b_sel = 1'b1;
                        end
                        ClsAuipc: begin
                            alu_a_sel = 2'd1;
                            alu_b_sel = 1'b1;
                        end
                        ClsBranch: begin
                            pc_we  = 1'b1;
                            pc_sel = branch_taken ? 2'd1 : 2'd0;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cls_q == ClsStore);
                    pc_we    = dmem_ready && (cls_q == ClsStore);
                end
                StWb: begin
                    rf_we  = (rd != 5'd0) && (cls_q != ClsFence);
                    pc_we  = 1'b1;
                    wb_sel = (cls_q == ClsLoad) ? 2'd1 :
                             (cls_q == ClsJal || cls_q == ClsJalr) ? 2'd2 : 2'd0;
                    pc_sel = (cls_q == ClsJal) ? 2'd1 : (cls_q == ClsJalr) ? 2'd2 : 2'd0;
                end
                StTrap: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: ;
            endcase
        end
    end

    assign state   = rst ? 3'd0 : state_q;
    assign instret = rst ? '0 : instret_q;

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the RV32I datapath around the instruction decoder, register file, ALU and memories.
- Drives the instruction/data memory handshakes, the IR/PC/register-file write enables and the datapath mux selects.
- Classifies the decoded opcode, retires one instruction at a time, and enters a sticky trap on illegal opcodes, ECALL/EBREAK or memory timeout.

Parameters:
- MEM_TIMEOUT, 255: max wait cycles for imem_ready/dmem_ready before trapping; 0 disables timeout.
- CNT_W, 32: width of instret counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  decoder opcode field
- rd  in  5  decoder rd field, used to suppress writes to x0
- branch_taken  in  1  branch comparator result, valid in EXEC
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req
- dmem_ready  in  1  data access complete this cycle
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result (JALR)
- alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero
- alu_b_sel  out  1  0 = rs2, 1 = imm
- rf_we  out  1  register file write
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4
- trap  out  1  sticky trap flag
- trap_cause  out  2  0 = illegal opcode, 1 = ECALL/EBREAK, 2 = imem timeout, 3 = dmem timeout
- state  out  3  current state encoding, for debug
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: while rst=1, every output is 0, including trap, trap_cause, instret and dmem_we. The state register loads FETCH and the wait counter loads 0.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 go to TRAP with cause 0.
- Output timing: control outputs are combinational from the state register, the latched class and the handshake inputs. All other state is registered.
- FETCH:
  - imem_req=1 every cycle.
  - On imem_ready=1: ir_we=1 the same cycle, next state DECODE, wait counter cleared.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT, go to TRAP with cause 2.
- DECODE (1 cycle): latch a class from opcode.
  - 0110011 R
  - 0010011 I-ALU
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH
  - 1101111 JAL
  - 1100111 JALR
  - 0110111 LUI
  - 0010111 AUIPC
  - 0001111 FENCE (treated as NOP)
  - 1110011 SYSTEM: go to TRAP, cause 1
  - any other opcode: go to TRAP, cause 0
  - All other classes go to EXEC.
- EXEC (1 cycle): selects per class.
  - R: a=0, b=0
  - I-ALU, LOAD, STORE, JALR: a=0, b=1
  - LUI: a=2, b=1
  - AUIPC: a=1, b=1
  - BRANCH: pc_we=1 and pc_sel = branch_taken ? 1 : 0. Next FETCH; instret increments.
  - LOAD/STORE: next MEM.
  - All other classes: next WB.
- MEM:
  - dmem_req=1 every cycle; dmem_we=1 for STORE, 0 for LOAD. The ALU address is held stable by the datapath.
  - On dmem_ready=1, STORE: pc_we=1, pc_sel=0, instret increments, next FETCH.
  - On dmem_ready=1, LOAD: next WB.
  - Timeout as in FETCH, giving cause 3.
- WB (1 cycle):
  - rf_we=1 if rd≠0 and class≠FENCE.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_we=1 with pc_sel: 1 for JAL, 2 for JALR, else 0.
  - instret increments; next FETCH.
- TRAP: absorbing.
  - trap=1; trap_cause holds the value latched on entry.
  - All request and enable outputs are 0; instret is frozen.
  - Only rst leaves this state.
- Latency, zero-wait memories:
  - BRANCH: 3 cycles
  - STORE: 4 cycles
  - ALU, LUI, AUIPC, JAL, JALR, FENCE: 4 cycles
  - LOAD: 5 cycles
- Boundaries:
  - A ready input seen outside FETCH/MEM is ignored.
  - Ready arriving on the same cycle the counter hits MEM_TIMEOUT is a success.
  - instret wraps modulo 2^CNT_W.
  - rst asserted mid-access drops the request the next cycle.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) with imem_ready held 1:
  - states 0,1,2,4; rf_we=1 in WB; wb_sel=0.
  - pc_we asserted once with pc_sel=0; instret=1 after 4 cycles.
- LW x5,0(x1) with dmem_ready delayed 3 cycles:
  - dmem_req=1 for 4 cycles with dmem_we=0.
  - then WB with wb_sel=1, rf_we=1; total 8 cycles.
- BEQ with branch_taken=1, then branch_taken=0:
  - pc_sel=1, then 0, both in EXEC; 3 cycles each.
  - rf_we never asserted.
- ADDI x0,x0,1 (0x00100013):
  - rf_we=0 in WB; pc_we=1; instret increments.
- Opcode 0x7F, then separately ECALL (0x00000073):
  - TRAP with cause 0 / cause 1; trap stays 1 for 20 cycles.
  - rst for 1 cycle returns to FETCH with trap=0.
- MEM_TIMEOUT=4 with imem_ready held 0:
  - TRAP with cause 2 after 5 FETCH cycles.
  - rst asserted during a MEM wait clears dmem_req the next cycle.
